// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, reads instruction_memory and queues {pc, inst} in a 2-entry prefetch buffer for decode.
// Latency: start sampled at edge N -> START_ADR on read_adr in N+1 -> out_valid from N+2; redirect at R -> target fetched in R+1.
// Backpressure: out_ready low lets the buffer fill to 2, then fetch stalls; a redirect flushes regardless of out_ready.
// Optional feature macro: FETCH_WRAP_EN (PC wraps to 0 at end of memory instead of draining and halting).

module fetch_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 9,
  parameter int START_ADR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] read_adr,
  input  logic [DATA_W-1:0] inst_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_adr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] LIMIT    = ADDR_W'(MEM_DEPTH * 4);
  localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADR);
  localparam logic [ADDR_W-1:0] WORD_MSK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count_q, count_d;

  // Entry 0 is always the head; entry 1 is only meaningful when count_q == 2.
  logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [DATA_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;

  logic              redir_act;
  logic              redir_in_range;
  logic [ADDR_W-1:0] redir_tgt;
  logic              start_act;
  logic              pop;
  logic              fetch;
  logic [ADDR_W-1:0] pc_inc;
  logic              pc_end;

  // Decode this cycle's events; a redirect outranks start, push and pop.
  always_comb begin
    redir_tgt      = redirect_adr & WORD_MSK;
    redir_in_range = (redir_tgt < LIMIT);
    redir_act      = redirect_valid && (state_q != ST_IDLE);
    start_act      = start && !redir_act &&
                     ((state_q == ST_IDLE) || (state_q == ST_HALT));
    pop            = (count_q != 2'd0) && out_ready;
    fetch          = (state_q == ST_RUN) && !redir_act &&
                     ((count_q != 2'd2) || pop);
    pc_inc         = pc_q + ADDR_W'(4);
    pc_end         = (pc_inc == LIMIT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (redir_act) begin
      if (redir_in_range) begin
        state_d = ST_RUN;
      end else begin
`ifdef FETCH_WRAP_EN
        state_d = ST_RUN;
`else
        // Out-of-range target: RUN winds down, DRAIN/HALT stay put.
        if (state_q == ST_RUN) begin
          state_d = ST_DRAIN;
        end
`endif
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_act) state_d = ST_RUN;
        end
        ST_RUN: begin
`ifdef FETCH_WRAP_EN
          state_d = ST_RUN;
`else
          if (fetch && pc_end) state_d = ST_DRAIN;
`endif
        end
        ST_DRAIN: begin
          if (count_q == 2'd0) state_d = ST_HALT;
        end
        ST_HALT: begin
          if (start_act) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and buffer head presentation.
  always_comb begin
    busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    halted    = (state_q == ST_HALT);
    out_valid = (count_q != 2'd0);
    read_adr  = pc_q;
    out_pc    = pc0_q;
    out_inst  = inst0_q;
  end

  // Next PC: redirect target, restart address, or sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (redir_act) begin
      if (redir_in_range) begin
        pc_d = redir_tgt;
      end else begin
`ifdef FETCH_WRAP_EN
        pc_d = '0;
`else
        // Clamp so the PC never points past the end of memory.
        pc_d = LIMIT;
`endif
      end
    end else if (start_act) begin
      pc_d = START;
    end else if (fetch) begin
`ifdef FETCH_WRAP_EN
      pc_d = pc_end ? '0 : pc_inc;
`else
      pc_d = pc_inc;
`endif
    end
  end

  // Prefetch buffer: flush on redirect, otherwise push at tail / pop from head.
  always_comb begin
    count_d = count_q;
    pc0_d   = pc0_q;
    inst0_d = inst0_q;
    pc1_d   = pc1_q;
    inst1_d = inst1_q;
    if (redir_act) begin
      count_d = 2'd0;
    end else begin
      unique case ({fetch, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_d   = pc_q;
            inst0_d = inst_in;
          end else begin
            pc1_d   = pc_q;
            inst1_d = inst_in;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          pc0_d   = pc1_q;
          inst0_d = inst1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            pc0_d   = pc_q;
            inst0_d = inst_in;
          end else begin
            pc0_d   = pc1_q;
            inst0_d = inst1_q;
            pc1_d   = pc_q;
            inst1_d = inst_in;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // PC and buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= START;
      count_q <= 2'd0;
      pc0_q   <= '0;
      inst0_q <= '0;
      pc1_q   <= '0;
      inst1_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      pc0_q   <= pc0_d;
      inst0_q <= inst0_d;
      pc1_q   <= pc1_d;
      inst1_q <= inst1_d;
    end
  end

  // Structural invariants of the buffer and PC.
  a_count_max: assert property (@(posedge clk) disable iff (!reset_n)
    count_q <= 2'd2);
  a_pc_bound: assert property (@(posedge clk) disable iff (!reset_n)
    pc_q <= LIMIT);
  a_head_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_ready && !redir_act) |=> ($stable(out_pc) && $stable(out_inst)));
  a_no_fetch_idle: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ST_IDLE) |-> (count_q == 2'd0));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed test-plan scenarios followed by random start/redirect/backpressure traffic.
// Expected {pc, inst} entries are queued by a transaction-level model and compared by a separate monitor.

module tb_fetch_sequencer;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 9;
  localparam int START_ADR = 0;
  localparam int LIMIT     = MEM_DEPTH * 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_adr = '0;
  logic        out_ready = 1'b0;
  logic [31:0] read_adr;
  logic [31:0] inst_in;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        busy;
  logic        halted;

  logic [31:0] mem [MEM_DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int          m_st = M_IDLE;
  logic [31:0] m_pc = START_ADR;
  ent_t        sb_q [$];

  always #5 clk = ~clk;

  // Behavioural instruction memory: combinational read, zero past the end.
  assign inst_in = (read_adr < LIMIT) ? mem[int'(read_adr >> 2)] : 32'h0;

  fetch_sequencer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH),
    .START_ADR(START_ADR)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .read_adr      (read_adr),
    .inst_in       (inst_in),
    .redirect_valid(redirect_valid),
    .redirect_adr  (redirect_adr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .busy          (busy),
    .halted        (halted)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // One clock of the transaction-level model: decides fetch/pop/flush from its own queue.
  task automatic model_step();
    bit          do_pop;
    bit          do_fetch;
    logic [31:0] tgt;
    int          n;
    ent_t        e;
    n      = sb_q.size();
    do_pop = (n > 0) && out_ready;
    if (redirect_valid && m_st != M_IDLE) begin
      tgt = redirect_adr & 32'hFFFF_FFFC;
      sb_q.delete();
      if (tgt < LIMIT) begin
        m_pc = tgt;
        m_st = M_RUN;
      end else begin
`ifdef FETCH_WRAP_EN
        m_pc = 0;
        m_st = M_RUN;
`else
        m_pc = LIMIT;
        if (m_st == M_RUN) m_st = M_DRAIN;
`endif
      end
    end else if (start && (m_st == M_IDLE || m_st == M_HALT)) begin
      m_pc = START_ADR;
      m_st = M_RUN;
    end else begin
      do_fetch = (m_st == M_RUN) && ((n < 2) || do_pop);
      if (m_st == M_DRAIN && n == 0) m_st = M_HALT;
      if (do_pop) void'(sb_q.pop_front());
      if (do_fetch) begin
        e.pc   = m_pc;
        e.inst = mem[int'(m_pc >> 2)];
        sb_q.push_back(e);
        m_pc = m_pc + 32'd4;
        if (m_pc == LIMIT) begin
`ifdef FETCH_WRAP_EN
          m_pc = 0;
`else
          m_st = M_DRAIN;
`endif
        end
      end
    end
  endtask

  // Model advances on the same edges as the DUT; reset clears it asynchronously.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_st = M_IDLE;
        m_pc = START_ADR;
        sb_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Monitor: compares presented head against the scoreboard front each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("mon_valid", {31'b0, out_valid}, {31'b0, sb_q.size() != 0});
        if (sb_q.size() != 0 && out_valid) begin
          chk("mon_pc", out_pc, sb_q[0].pc);
          chk("mon_inst", out_inst, sb_q[0].inst);
        end
        chk("mon_read_adr", read_adr, m_pc);
        chk("mon_busy", {31'b0, busy}, {31'b0, (m_st == M_RUN) || (m_st == M_DRAIN)});
        chk("mon_halted", {31'b0, halted}, {31'b0, m_st == M_HALT});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    start          = 1'b0;
    redirect_valid = 1'b0;
    reset_n        = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Stimulus driver: directed scenarios then random traffic.
  initial begin
    mem[0] = 32'h00410021;
    mem[1] = 32'h010B5022;
    for (int i = 2; i < MEM_DEPTH; i++) mem[i] = $urandom;

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_read_adr", read_adr, START_ADR);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    reset_n = 1'b1;

    // Sequential fetch from start
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);                       // cycle N+1
    start = 1'b0;
    chk("lat_n1_valid", {31'b0, out_valid}, 32'd0);
    chk("lat_n1_adr", read_adr, START_ADR);
    @(negedge clk);                       // cycle N+2
    chk("lat_n2_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_n2_pc", out_pc, 32'd0);
    chk("lat_n2_inst", out_inst, 32'h00410021);
    @(negedge clk);                       // cycle N+3
    chk("seq_pc1", out_pc, 32'd4);
    chk("seq_inst1", out_inst, 32'h010B5022);
    repeat (9) @(negedge clk);            // cycle N+12
`ifndef FETCH_WRAP_EN
    chk("seq_halted_n12", {31'b0, halted}, 32'd1);
`endif

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);                       // N+1
    start = 1'b0;
    repeat (5) @(negedge clk);            // N+6
    chk("bp_read_adr", read_adr, 32'd8);
    chk("bp_out_pc", out_pc, 32'd0);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_pc4", out_pc, 32'd4);
    @(negedge clk);
    chk("bp_resume_pc8", out_pc, 32'd8);
    repeat (12) @(negedge clk);

    // Redirect with a full buffer
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_adr   = 32'd28;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd_setup_pc", out_pc, 32'd28);
    redirect_valid = 1'b1;
    redirect_adr   = 32'd9;
    @(negedge clk);                       // R+1
    redirect_valid = 1'b0;
    chk("rd_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("rd_target_adr", read_adr, 32'd8);
    @(negedge clk);                       // R+2
    chk("rd_valid", {31'b0, out_valid}, 32'd1);
    chk("rd_pc", out_pc, 32'd8);
    chk("rd_inst", out_inst, mem[2]);

    // Redirect in the same cycle as a pop with count 2
    @(negedge clk);                       // R+3, count 2
    redirect_valid = 1'b1;
    redirect_adr   = 32'd4;
    out_ready      = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    chk("rs_flush_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("rs_pc", out_pc, 32'd4);
    chk("rs_inst", out_inst, mem[1]);

    // Reset mid-run with a full buffer
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_read_adr", read_adr, START_ADR);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_idle_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_idle_adr", read_adr, START_ADR);

    // Random traffic
    repeat (2000) begin
      @(negedge clk);
      out_ready      = ($urandom_range(3) != 0);
      redirect_valid = 1'b0;
      start          = 1'b0;
      if ($urandom_range(14) == 0) begin
        redirect_valid = 1'b1;
        if (m_st == M_HALT) redirect_adr = $urandom_range(LIMIT - 1);
        else                redirect_adr = $urandom_range(LIMIT + 11);
      end else if ($urandom_range(9) == 0) begin
        start = 1'b1;
      end
    end
    @(negedge clk);
    start          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
